// File: rtl/alu_issue_stage.sv
`default_nettype none
// ============================================================================
// Module   : alu_issue_stage
// Purpose  : Command FIFO + issue FSM in front of alu_4bit, with a
//            valid/ready result register. Optional macro ALU_ISSUE_CHAIN_EN
//            lets a command take its X operand from the previous result.
// Revision : 1.0 - initial release
// ============================================================================
module alu_issue_stage #(
    parameter int DEPTH = 4
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [2:0]              in_op,
    input  logic [3:0]              in_x,
    input  logic [3:0]              in_y,
    input  logic                    in_chain,
    output logic [3:0]              alu_x,
    output logic [3:0]              alu_y,
    output logic [2:0]              alu_sel,
    input  logic [3:0]              alu_out,
    input  logic                    alu_cout,
    input  logic                    alu_zero,
    output logic                    res_valid,
    input  logic                    res_ready,
    output logic [3:0]              res_data,
    output logic                    res_cout,
    output logic                    res_zero,
    output logic [$clog2(DEPTH):0]  fifo_count
);

    localparam int              c_AW        = $clog2(DEPTH);
    localparam logic [c_AW:0]   c_FULL      = DEPTH[c_AW:0];
    localparam logic [1:0]      c_ST_IDLE   = 2'd0;
    localparam logic [1:0]      c_ST_EXEC   = 2'd1;
    localparam logic [1:0]      c_ST_RESULT = 2'd2;

    logic [1:0]       r_state;
    logic [c_AW-1:0]  r_wr_ptr;
    logic [c_AW-1:0]  r_rd_ptr;
    logic [c_AW:0]    r_count;
    logic [2:0]       r_mem_op [DEPTH];
    logic [3:0]       r_mem_x  [DEPTH];
    logic [3:0]       r_mem_y  [DEPTH];
    logic [3:0]       r_op_x;
    logic [3:0]       r_op_y;
    logic [2:0]       r_op_sel;
    logic             r_res_valid;
    logic [3:0]       r_res_data;
    logic             r_res_cout;
    logic             r_res_zero;
    logic             w_push;
    logic             w_pop;
    logic [3:0]       w_head_x;

`ifdef ALU_ISSUE_CHAIN_EN
    logic             r_mem_chain [DEPTH];
    logic [3:0]       r_chain;

    assign w_head_x = r_mem_chain[r_rd_ptr] ? r_chain : r_mem_x[r_rd_ptr];

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem_chain[r_wr_ptr] <= in_chain;
        end
    end

    // The chain value is the most recent captured ALU result.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_chain <= 4'd0;
        end else if (r_state == c_ST_EXEC) begin
            r_chain <= alu_out;
        end
    end
`else
    logic             w_unused_chain;

    assign w_unused_chain = in_chain;
    assign w_head_x       = r_mem_x[r_rd_ptr];
`endif

    assign in_ready   = rst_n && (r_count != c_FULL);
    assign w_push     = in_valid && in_ready;
    // A command pushed into an empty FIFO becomes visible only via r_count next cycle.
    assign w_pop      = (r_count != '0) &&
                        ((r_state == c_ST_IDLE) || ((r_state == c_ST_RESULT) && res_ready));

    assign alu_x      = r_op_x;
    assign alu_y      = r_op_y;
    assign alu_sel    = r_op_sel;
    assign res_valid  = r_res_valid;
    assign res_data   = r_res_data;
    assign res_cout   = r_res_cout;
    assign res_zero   = r_res_zero;
    assign fifo_count = r_count;

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem_op[r_wr_ptr] <= in_op;
            r_mem_x[r_wr_ptr]  <= in_x;
            r_mem_y[r_wr_ptr]  <= in_y;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state     <= c_ST_IDLE;
            r_op_x      <= 4'd0;
            r_op_y      <= 4'd0;
            r_op_sel    <= 3'd0;
            r_res_valid <= 1'b0;
            r_res_data  <= 4'd0;
            r_res_cout  <= 1'b0;
            r_res_zero  <= 1'b0;
        end else begin
            if (w_pop) begin
                r_op_x   <= w_head_x;
                r_op_y   <= r_mem_y[r_rd_ptr];
                r_op_sel <= r_mem_op[r_rd_ptr];
            end
            case (r_state)
                c_ST_IDLE: begin
                    if (w_pop) begin
                        r_state <= c_ST_EXEC;
                    end
                end
                c_ST_EXEC: begin
                    r_res_data  <= alu_out;
                    r_res_cout  <= alu_cout;
                    r_res_zero  <= alu_zero;
                    r_res_valid <= 1'b1;
                    r_state     <= c_ST_RESULT;
                end
                c_ST_RESULT: begin
                    if (res_ready) begin
                        r_res_valid <= 1'b0;
                        r_state     <= w_pop ? c_ST_EXEC : c_ST_IDLE;
                    end
                end
                default: begin
                    r_state <= c_ST_IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_alu_issue_stage.sv
`default_nettype none
// ============================================================================
// Module   : tb_alu_issue_stage
// Purpose  : Randomized + directed bench for alu_issue_stage with a
//            behavioural ALU and a queue-based result model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_alu_issue_stage;

    localparam int c_DEPTH = 4;
`ifdef ALU_ISSUE_CHAIN_EN
    localparam logic [3:0] c_CHAIN_EXP = 4'd6;
`else
    localparam logic [3:0] c_CHAIN_EXP = 4'd1;
`endif

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_chain = 1'b0;
    logic        res_ready = 1'b0;
    logic [2:0]  in_op = 3'd0;
    logic [3:0]  in_x = 4'd0;
    logic [3:0]  in_y = 4'd0;
    logic        in_ready;
    logic [3:0]  alu_x;
    logic [3:0]  alu_y;
    logic [2:0]  alu_sel;
    logic [3:0]  alu_out;
    logic        alu_cout;
    logic        alu_zero;
    logic        res_valid;
    logic [3:0]  res_data;
    logic        res_cout;
    logic        res_zero;
    logic [2:0]  fifo_count;

    int          total = 0;
    int          bad = 0;
    int          cyc = 0;

    // {cout, zero, out}: ADD SUB AND OR XOR NAND NOR XNOR
    function automatic logic [5:0] alu_f(input logic [2:0] op, input logic [3:0] a, input logic [3:0] b);
        logic [4:0] t;
        t = 5'd0;
        case (op)
            3'd0: t = {1'b0, a} + {1'b0, b};
            3'd1: t = {1'b0, a} - {1'b0, b};
            3'd2: t = {1'b0, a & b};
            3'd3: t = {1'b0, a | b};
            3'd4: t = {1'b0, a ^ b};
            3'd5: t = {1'b0, ~(a & b)};
            3'd6: t = {1'b0, ~(a | b)};
            default: t = {1'b0, ~(a ^ b)};
        endcase
        return {t[4], (t[3:0] == 4'd0), t[3:0]};
    endfunction

    assign {alu_cout, alu_zero, alu_out} = alu_f(alu_sel, alu_x, alu_y);

    alu_issue_stage #(.DEPTH(c_DEPTH)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .in_op(in_op), .in_x(in_x), .in_y(in_y), .in_chain(in_chain),
        .alu_x(alu_x), .alu_y(alu_y), .alu_sel(alu_sel),
        .alu_out(alu_out), .alu_cout(alu_cout), .alu_zero(alu_zero),
        .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data),
        .res_cout(res_cout), .res_zero(res_zero), .fifo_count(fifo_count)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    // Reference model: commands in push order, results retired in the same order.
    logic [11:0] mq[$];
    logic [3:0]  m_chain = 4'd0;
    logic        held = 1'b0;
    logic [5:0]  held_val = 6'd0;

    always @(negedge clk) begin
        logic [11:0] cmd;
        logic [3:0]  ex;
        logic [5:0]  expv;
        if (!rst_n) begin
            mq.delete();
            m_chain = 4'd0;
            held = 1'b0;
        end else begin
            if (held && res_valid)
                check_eq("hold_stable", {26'd0, res_cout, res_zero, res_data}, {26'd0, held_val});
            if (res_valid && res_ready) begin
                if (mq.size() == 0) begin
                    check_eq("spurious_result", 1, 0);
                end else begin
                    cmd = mq.pop_front();
`ifdef ALU_ISSUE_CHAIN_EN
                    ex = cmd[11] ? m_chain : cmd[7:4];
`else
                    ex = cmd[7:4];
`endif
                    expv = alu_f(cmd[10:8], ex, cmd[3:0]);
                    check_eq("result", {26'd0, res_cout, res_zero, res_data}, {26'd0, expv});
                    m_chain = expv[3:0];
                end
            end
            held = res_valid && !res_ready;
            held_val = {res_cout, res_zero, res_data};
            if (in_valid && in_ready)
                mq.push_back({in_chain, in_op, in_x, in_y});
        end
    end

    task automatic push(input logic [2:0] op, input logic [3:0] x, input logic [3:0] y, input logic c);
        int n;
        n = 0;
        in_valid = 1'b1; in_op = op; in_x = x; in_y = y; in_chain = c;
        @(negedge clk);
        while (!in_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready) check_eq("push_timeout", 0, 1);
        @(posedge clk);
        #1 in_valid = 1'b0;
    endtask

    task automatic wait_valid(input string tag);
        int n;
        n = 0;
        @(negedge clk);
        while (!res_valid && n < 30) begin
            @(negedge clk);
            n++;
        end
        check_eq(tag, {31'd0, res_valid}, 1);
    endtask

    task automatic take();
        res_ready = 1'b1;
        @(posedge clk);
        #1 res_ready = 1'b0;
    endtask

    initial begin
        int acc;
        int last;
        int n;
        logic [3:0] ax;

        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;

        // Single op latency
        in_valid = 1'b1; in_op = 3'd0; in_x = 4'd3; in_y = 4'd1; in_chain = 1'b0;
        @(negedge clk);
        check_eq("single_in_ready", {31'd0, in_ready}, 1);
        @(posedge clk);
        #1 in_valid = 1'b0;
        @(negedge clk); check_eq("lat_e0", {31'd0, res_valid}, 0);
        @(negedge clk); check_eq("lat_e1", {31'd0, res_valid}, 0);
        check_eq("exec_alu_x", {28'd0, alu_x}, 3);
        @(negedge clk); check_eq("lat_e2", {31'd0, res_valid}, 1);
        check_eq("single_data", {28'd0, res_data}, 4);
        check_eq("single_zero", {31'd0, res_zero}, 0);
        take();

        // Fill FIFO with result held
        acc = 0;
        in_valid = 1'b1;
        for (int i = 0; i < 12; i++) begin
            in_op = 3'($urandom); in_x = 4'($urandom); in_y = 4'($urandom); in_chain = 1'b0;
            @(negedge clk);
            if (!in_ready) break;
            acc++;
            @(posedge clk);
            #1;
        end
        check_eq("full_count", {29'd0, fifo_count}, c_DEPTH);
        check_eq("full_in_ready", {31'd0, in_ready}, 0);
        check_eq("full_accepted", acc, c_DEPTH + 1);
        in_valid = 1'b0;
        res_ready = 1'b1;
        last = 0;
        for (int k = 0; k < c_DEPTH; k++) begin
            n = 0;
            do begin
                @(negedge clk);
                n++;
            end while (!res_valid && n < 20);
            check_eq("drain_valid", {31'd0, res_valid}, 1);
            if (k > 0) check_eq("throughput_gap", cyc - last, 2);
            last = cyc;
        end
        @(posedge clk);
        #1 res_ready = 1'b0;

        // Backpressure
        push(3'd1, 4'd3, 4'd3, 1'b0);
        wait_valid("bp_valid");
        @(posedge clk);
        #1;
        push(3'd0, 4'd1, 4'd1, 1'b0);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check_eq("bp_valid_hold", {31'd0, res_valid}, 1);
            check_eq("bp_data", {28'd0, res_data}, 0);
            check_eq("bp_zero", {31'd0, res_zero}, 1);
            check_eq("bp_no_pop", {29'd0, fifo_count}, 1);
        end
        take();
        @(negedge clk);
        check_eq("bp_popped", {29'd0, fifo_count}, 0);
        check_eq("bp_valid_clear", {31'd0, res_valid}, 0);
        wait_valid("bp_second");
        take();

        // Chain
        push(3'd0, 4'd2, 4'd3, 1'b0);
        wait_valid("chain_first_v");
        check_eq("chain_first", {28'd0, res_data}, 5);
        take();
        push(3'd0, 4'd0, 4'd1, 1'b1);
        wait_valid("chain_second_v");
        check_eq("chain_second", {28'd0, res_data}, {28'd0, c_CHAIN_EXP});
        take();

        // Reset mid-traffic
        push(3'd2, 4'd7, 4'd5, 1'b0);
        push(3'd3, 4'd1, 4'd8, 1'b0);
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_eq("rst_res_valid", {31'd0, res_valid}, 0);
        check_eq("rst_res", {26'd0, res_cout, res_zero, res_data}, 0);
        check_eq("rst_alu", {21'd0, alu_sel, alu_x, alu_y}, 0);
        check_eq("rst_count", {29'd0, fifo_count}, 0);
        check_eq("rst_in_ready", {31'd0, in_ready}, 0);
        rst_n = 1'b1;
        #1 check_eq("rel_in_ready", {31'd0, in_ready}, 1);
        @(posedge clk);
        #1;

        // Reset on the cycle before capture
        res_ready = 1'b1;
        ax = 4'd9;
        push(3'd4, ax, 4'd6, 1'b0);
        in_valid = 1'b1; in_op = 3'd0; in_x = 4'd2; in_y = 4'd2; in_chain = 1'b0;
        @(posedge clk);
        #1 in_valid = 1'b0;
        check_eq("rexec_alu_x", {28'd0, alu_x}, {28'd0, ax});
        rst_n = 1'b0;
        @(posedge clk);
        #1 rst_n = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            check_eq("rexec_no_pulse", {31'd0, res_valid}, 0);
            check_eq("rexec_empty", {29'd0, fifo_count}, 0);
        end
        @(posedge clk);
        #1;

        // Random traffic
        for (int i = 0; i < 400; i++) begin
            in_valid = 1'($urandom);
            in_op = 3'($urandom); in_x = 4'($urandom); in_y = 4'($urandom);
            in_chain = 1'($urandom);
            res_ready = ($urandom_range(0, 3) != 0);
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
        res_ready = 1'b1;
        n = 0;
        while ((mq.size() != 0 || res_valid) && n < 100) begin
            @(negedge clk);
            n++;
        end
        check_eq("drain_model_empty", mq.size(), 0);
        check_eq("drain_count", {29'd0, fifo_count}, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
